// File: rtl/wb_arbiter.sv
// Register-file write arbiter: pipeline results win, divide results queue.
// Define WB_DIV_BYPASS_EN to let divide results skip an empty FIFO.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipe_valid,
  input  logic [4:0]             pipe_rd,
  input  logic [XLEN-1:0]        pipe_wd,
  input  logic                   div_valid,
  input  logic [4:0]             div_rd,
  input  logic [XLEN-1:0]        div_wd,
  output logic                   div_ready,
  output logic                   we,
  output logic [4:0]             waddr,
  output logic [XLEN-1:0]        wd,
  output logic [31:0]            pend_mask,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0] live_q;
  logic [4:0]       rd_q  [DEPTH];
  logic [XLEN-1:0]  dat_q [DEPTH];
  logic [AW-1:0]    head_q;
  logic [AW-1:0]    tail_q;
  logic [CW-1:0]    cnt_q;

  logic pipe_hit;
  logic fifo_nz;
  logic pop;
  logic push;
  logic byp;

  assign pipe_hit   = pipe_valid && (pipe_rd != 5'd0);
  assign fifo_nz    = (cnt_q != '0);
  assign pop        = !pipe_hit && fifo_nz;
  assign div_ready  = (cnt_q < FULL);
  assign fifo_count = cnt_q;

`ifdef WB_DIV_BYPASS_EN
  assign byp = !pipe_hit && !fifo_nz &&
               div_valid && (div_rd != 5'd0);
`else
  assign byp = 1'b0;
`endif

  assign push = div_valid && div_ready &&
                (div_rd != 5'd0) && !byp;

  // live bits are cleared on pop, so live implies occupied
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (live_q[i])
        pend_mask[rd_q[i]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we     <= 1'b0;
      waddr  <= '0;
      wd     <= '0;
      live_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      if (pipe_hit) begin
        we    <= 1'b1;
        waddr <= pipe_rd;
        wd    <= pipe_wd;
        for (int i = 0; i < DEPTH; i++)
          if (live_q[i] && rd_q[i] == pipe_rd)
            live_q[i] <= 1'b0;
      end else if (pop) begin
        we <= live_q[head_q];
        if (live_q[head_q]) begin
          waddr <= rd_q[head_q];
          wd    <= dat_q[head_q];
        end
        live_q[head_q] <= 1'b0;
        head_q         <= head_q + AW'(1);
      end else if (byp) begin
        we    <= 1'b1;
        waddr <= div_rd;
        wd    <= div_wd;
      end else begin
        we <= 1'b0;
      end
      // push lands on a free slot, so it never collides with a kill
      if (push) begin
        live_q[tail_q] <= 1'b1;
        rd_q[tail_q]   <= div_rd;
        dat_q[tail_q]  <= div_wd;
        tail_q         <= tail_q + AW'(1);
      end
      if (push && !pop)
        cnt_q <= cnt_q + CW'(1);
      else if (pop && !push)
        cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model plus
// directed literal checks and randomized traffic.
module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
`ifdef WB_DIV_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    bit          live;
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wd;
  logic        div_valid;
  logic [4:0]  div_rd;
  logic [31:0] div_wd;
  logic        div_ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wd;
  logic [31:0] pend_mask;
  logic [2:0]  fifo_count;

  wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd),
    .pipe_wd(pipe_wd),
    .div_valid(div_valid), .div_rd(div_rd),
    .div_wd(div_wd), .div_ready(div_ready),
    .we(we), .waddr(waddr), .wd(wd),
    .pend_mask(pend_mask), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t        q[$];
  bit          exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wd;
  bit          known;
  logic [31:0] mrf [32];
  logic [31:0] drf [32];
  int          n_chk;
  int          n_fail;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (q[i])
      if (q[i].live) m[q[i].rd] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_we    = 1'b0;
    exp_waddr = '0;
    exp_wd    = '0;
    known     = 1'b1;
  endtask

  // Called just after a posedge; drives, predicts, clocks, checks.
  task automatic cycle(input bit pv,
                       input logic [4:0] prd,
                       input logic [31:0] pwd,
                       input bit dv,
                       input logic [4:0] drd,
                       input logic [31:0] dwd);
    bit   rdy;
    bit   byp;
    ent_t e;
    pipe_valid = pv;
    pipe_rd    = prd;
    pipe_wd    = pwd;
    div_valid  = dv;
    div_rd     = drd;
    div_wd     = dwd;
    rdy = (q.size() < DEPTH);
    byp = 1'b0;
    chk("div_ready", div_ready, rdy);
    if (pv && prd != 0) begin
      exp_we    = 1'b1;
      exp_waddr = prd;
      exp_wd    = pwd;
      known     = 1'b1;
      foreach (q[i])
        if (q[i].live && q[i].rd == prd)
          q[i].live = 1'b0;
    end else if (q.size() > 0) begin
      e      = q.pop_front();
      exp_we = e.live;
      if (e.live) begin
        exp_waddr = e.rd;
        exp_wd    = e.wd;
        known     = 1'b1;
      end else begin
        known = 1'b0;
      end
    end else if (BYP && dv && drd != 0) begin
      exp_we    = 1'b1;
      exp_waddr = drd;
      exp_wd    = dwd;
      known     = 1'b1;
      byp       = 1'b1;
    end else begin
      exp_we = 1'b0;
    end
    if (dv && rdy && drd != 0 && !byp)
      q.push_back('{1'b1, drd, dwd});
    if (exp_we) mrf[exp_waddr] = exp_wd;
    @(posedge clk);
    #1;
    chk("we", we, exp_we);
    if (exp_we || known) begin
      chk("waddr", waddr, exp_waddr);
      chk("wd", wd, exp_wd);
    end
    chk("fifo_count", fifo_count, q.size());
    chk("pend_mask", pend_mask, model_mask());
    chk("x0_write", (we && waddr == 5'd0), 0);
    if (we) drf[waddr] = wd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 32; i++) begin
      mrf[i] = '0;
      drf[i] = '0;
    end
    rst        = 1'b0;
    pipe_valid = 1'b0;
    pipe_rd    = '0;
    pipe_wd    = '0;
    div_valid  = 1'b0;
    div_rd     = '0;
    div_wd     = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wd", wd, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_pend", pend_mask, 0);
    rst = 1'b1;
    #1;
    chk("rst_ready", div_ready, 1);

    // pipeline only
    cycle(1, 5, 32'h1234, 0, 0, 0);
    chk("pipe_we", we, 1);
    chk("pipe_waddr", waddr, 5);
    chk("pipe_wd", wd, 32'h1234);
    cycle(1, 0, 32'hdead, 0, 0, 0);
    chk("pipe_x0_we", we, 0);

    // contention
    cycle(1, 3, 32'h33, 1, 7, 32'hAA);
    chk("cont_waddr1", waddr, 3);
    chk("cont_pend1", pend_mask, 32'h80);
    cycle(0, 0, 0, 0, 0, 0);
    chk("cont_we2", we, 1);
    chk("cont_waddr2", waddr, 7);
    chk("cont_wd2", wd, 32'hAA);
    chk("cont_pend2", pend_mask, 0);

    // full
    for (int k = 0; k < 4; k++)
      cycle(1, 1, k, 1, 5'(10 + k), 32'h100 + k);
    chk("full_count", fifo_count, 4);
    chk("full_ready", div_ready, 0);
    cycle(1, 1, 9, 1, 20, 32'hbad);
    chk("full_count2", fifo_count, 4);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, 0, 0, 0);
      chk("drain_we", we, 1);
      chk("drain_waddr", waddr, 5'(10 + k));
      chk("drain_wd", wd, 32'h100 + k);
    end
    chk("drain_count", fifo_count, 0);
    chk("drain_ready", div_ready, 1);

    // WAW kill
    cycle(1, 2, 32'h2, 1, 9, 32'h11);
    chk("waw_pend_set", pend_mask, 32'h200);
    cycle(1, 9, 32'h22, 0, 0, 0);
    chk("waw_pend_kill", pend_mask, 0);
    chk("waw_count", fifo_count, 1);
    cycle(0, 0, 0, 0, 0, 0);
    chk("waw_pop_we", we, 0);
    chk("waw_x9", drf[9], 32'h22);

    // younger push with same rd is not killed
    cycle(1, 6, 32'h66, 1, 6, 32'h67);
    chk("young_pend", pend_mask, 32'h40);
    cycle(0, 0, 0, 0, 0, 0);
    chk("young_wd", wd, 32'h67);

    // bypass latency
    cycle(0, 0, 0, 1, 4, 32'h55);
`ifdef WB_DIV_BYPASS_EN
    chk("byp_we", we, 1);
    chk("byp_waddr", waddr, 4);
    chk("byp_count", fifo_count, 0);
`else
    chk("nobyp_we", we, 0);
    chk("nobyp_count", fifo_count, 1);
`endif
    cycle(0, 0, 0, 0, 0, 0);
`ifndef WB_DIV_BYPASS_EN
    chk("nobyp_we2", we, 1);
    chk("nobyp_wd2", wd, 32'h55);
`endif

    // reset mid-traffic with 3 entries queued
    for (int k = 0; k < 3; k++)
      cycle(1, 1, k, 1, 5'(20 + k), k);
    chk("pre_rst_count", fifo_count, 3);
    rst = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_we", we, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_pend", pend_mask, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", div_ready, 1);

    // randomized traffic
    for (int n = 0; n < 600; n++)
      cycle($urandom_range(0, 99) < 45,
            5'($urandom_range(0, 7)),
            $urandom,
            $urandom_range(0, 99) < 55,
            5'($urandom_range(0, 7)),
            $urandom);
    idle(DEPTH + 1);
    for (int r = 1; r < 8; r++)
      chk("rf_final", drf[r], mrf[r]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
